// File: rtl/onchip_ram_pkg.sv
// Shared definitions for the on-chip RAM arbiter: FSM encoding, port indices
// and the default RAM byte-address width.
package onchip_ram_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 12;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DATA   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_arb_rr2.sv
// Combinational two-way round-robin pick: a lone eligible port wins outright,
// and on contention the port that was not granted last wins.
module ram_arb_rr2
  import onchip_ram_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |elig;
    winner = elig[1] ? PORT_AUX : PORT_CPU;
    if (&elig) begin
      winner = (last_grant == PORT_CPU) ? PORT_AUX : PORT_CPU;
    end
  end

endmodule

// File: rtl/onchip_ram_arb.sv
// Two-port arbiter/sequencer in front of the single-port onchip_ram: grants in
// IDLE, holds RAM inputs for one ACCESS cycle, captures read data in DATA.
module onchip_ram_arb
  import onchip_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic                  p0_lock,
  input  logic [1:0]            p0_be,
  input  logic [ADDR_WIDTH-2:0] p0_addr,
  input  logic [15:0]           p0_wdata,
  output logic [15:0]           p0_rdata,
  output logic                  p0_ack,

  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [1:0]            p1_be,
  input  logic [ADDR_WIDTH-2:0] p1_addr,
  input  logic [15:0]           p1_wdata,
  output logic [15:0]           p1_rdata,
  output logic                  p1_ack,

  output logic                  ram_wren,
  output logic [1:0]            ram_byteena,
  output logic [ADDR_WIDTH-2:0] ram_address,
  output logic [15:0]           ram_data,
  input  logic [15:0]           ram_q
);

  arb_state_e            state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  wr_q, wr_d;
  logic                  last_grant_q, last_grant_d;
  logic                  locked_q, locked_d;
  logic                  p0_ack_q, p0_ack_d;
  logic                  p1_ack_q, p1_ack_d;
  logic [15:0]           p0_rdata_q, p0_rdata_d;
  logic [15:0]           p1_rdata_q, p1_rdata_d;
  logic                  ram_wren_q, ram_wren_d;
  logic [1:0]            ram_byteena_q, ram_byteena_d;
  logic [ADDR_WIDTH-2:0] ram_address_q, ram_address_d;
  logic [15:0]           ram_data_q, ram_data_d;

  logic [1:0] elig;
  logic       pick;
  logic       pick_valid;

  // A port whose ack is showing this cycle is masked so its finished request
  // is not granted a second time before the requester reacts.
  assign elig[0] = p0_req & ~p0_ack_q;
  assign elig[1] = p1_req & ~p1_ack_q & ~locked_q;

  ram_arb_rr2 u_rr2 (
    .elig       (elig),
    .last_grant (last_grant_q),
    .winner     (pick),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    wr_d          = wr_q;
    last_grant_d  = last_grant_q;
    locked_d      = locked_q;
    p0_ack_d      = 1'b0;
    p1_ack_d      = 1'b0;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    ram_wren_d    = ram_wren_q;
    ram_byteena_d = ram_byteena_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid && pick == PORT_CPU) begin
          locked_d = p0_lock;
        end else if (!p0_req) begin
          locked_d = 1'b0;
        end
        if (pick_valid) begin
          gnt_d        = pick;
          last_grant_d = pick;
          state_d      = ST_ACCESS;
          if (pick == PORT_CPU) begin
            wr_d          = p0_wr;
            ram_wren_d    = p0_wr & (p0_be != '0);
            ram_byteena_d = p0_be;
            ram_address_d = p0_addr;
            ram_data_d    = p0_wdata;
          end else begin
            wr_d          = p1_wr;
            ram_wren_d    = p1_wr & (p1_be != '0);
            ram_byteena_d = p1_be;
            ram_address_d = p1_addr;
            ram_data_d    = p1_wdata;
          end
        end
      end
      ST_ACCESS: begin
        ram_wren_d = 1'b0;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (gnt_q == PORT_CPU) begin
          p0_ack_d = 1'b1;
          if (!wr_q) p0_rdata_d = ram_q;
        end else begin
          p1_ack_d = 1'b1;
          if (!wr_q) p1_rdata_d = ram_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= PORT_CPU;
      wr_q          <= 1'b0;
      last_grant_q  <= PORT_AUX;
      locked_q      <= 1'b0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
      ram_wren_q    <= 1'b0;
      ram_byteena_q <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      wr_q          <= wr_d;
      last_grant_q  <= last_grant_d;
      locked_q      <= locked_d;
      p0_ack_q      <= p0_ack_d;
      p1_ack_q      <= p1_ack_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
      ram_wren_q    <= ram_wren_d;
      ram_byteena_q <= ram_byteena_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
    end
  end

  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign ram_wren    = ram_wren_q;
  assign ram_byteena = ram_byteena_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;

endmodule

// File: tb/tb_onchip_ram_arb.sv
// Directed bench for onchip_ram_arb with a behavioural synchronous RAM behind it.
module tb_onchip_ram_arb;

  localparam int unsigned AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0, p0_wr = 1'b0, p0_lock = 1'b0;
  logic [1:0]    p0_be = 2'b11;
  logic [AW-2:0] p0_addr = '0;
  logic [15:0]   p0_wdata = '0;
  logic [15:0]   p0_rdata;
  logic          p0_ack;
  logic          p1_req = 1'b0, p1_wr = 1'b0;
  logic [1:0]    p1_be = 2'b11;
  logic [AW-2:0] p1_addr = '0;
  logic [15:0]   p1_wdata = '0;
  logic [15:0]   p1_rdata;
  logic          p1_ack;
  logic          ram_wren;
  logic [1:0]    ram_byteena;
  logic [AW-2:0] ram_address;
  logic [15:0]   ram_data;
  logic [15:0]   ram_q;

  logic [15:0]   mem [0:(1<<(AW-1))-1];
  logic          bd_we = 1'b0;
  logic [AW-2:0] bd_addr = '0;
  logic [15:0]   bd_data = '0;

  int n_chk = 0;
  int n_err = 0;

  onchip_ram_arb #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_lock(p0_lock), .p0_be(p0_be),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_be(p1_be),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .ram_wren(ram_wren), .ram_byteena(ram_byteena), .ram_address(ram_address),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM: address registered on the edge, q valid the next cycle.
  always @(posedge clock) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_wren) begin
      if (ram_byteena[0]) mem[ram_address][7:0]  <= ram_data[7:0];
      if (ram_byteena[1]) mem[ram_address][15:8] <= ram_data[15:8];
    end
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-2:0] a, input logic [15:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Runs one transaction on a port; lat = ticks until ack (0 = timed out),
  // wpat bit k = ram_wren seen k+1 ticks after the request was presented.
  task automatic do_access(input logic port, input logic wr, input logic lock,
                           input logic [1:0] be, input logic [AW-2:0] addr,
                           input logic [15:0] wd, output int lat,
                           output logic [15:0] rd, output logic [7:0] wpat);
    lat = 0; rd = '0; wpat = '0;
    if (port) begin
      p1_wr = wr; p1_be = be; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
    end else begin
      p0_wr = wr; p0_lock = lock; p0_be = be; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      wpat[k-1] = ram_wren;
      if (port ? p1_ack : p0_ack) begin
        lat = k;
        rd = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] rd;
    logic [7:0]  wpat;

    preload(11'h010, 16'hBEEF);
    preload(11'h020, 16'h5566);

    do_reset();
    chk("rst_p0_ack",   32'(p0_ack), 32'd0);
    chk("rst_p1_ack",   32'(p1_ack), 32'd0);
    chk("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    chk("rst_p1_rdata", 32'(p1_rdata), 32'd0);
    chk("rst_ram_ctl",  32'({ram_wren, ram_byteena, ram_address}), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);

    // Single read
    do_access(1'b0, 1'b0, 1'b0, 2'b11, 11'h010, 16'h0000, lat, rd, wpat);
    chk("rd_lat",  32'(lat), 32'd3);
    chk("rd_data", 32'(rd), 32'hBEEF);
    chk("rd_wren", 32'(wpat), 32'd0);

    // Byte write over 16'h5566, low byte only
    tick();
    do_access(1'b1, 1'b1, 1'b0, 2'b01, 11'h020, 16'h12AB, lat, rd, wpat);
    chk("bw_lat",  32'(lat), 32'd3);
    chk("bw_wren", 32'(wpat), 32'b001);
    tick();
    chk("bw_mem",  32'(mem[11'h020]), 32'h55AB);

    // Contention from reset: p0 wins first, then alternation every 3 cycles
    do_reset();
    p0_wr = 1'b0; p0_lock = 1'b0; p0_be = 2'b11; p0_addr = 11'h010; p0_req = 1'b1;
    p1_wr = 1'b0; p1_be = 2'b11; p1_addr = 11'h020; p1_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("cont_ack0", 32'(p0_ack), 32'((k == 3) || (k == 9)));
      chk("cont_ack1", 32'(p1_ack), 32'((k == 6) || (k == 12)));
      if (k == 3) chk("cont_rd0", 32'(p0_rdata), 32'hBEEF);
      if (k == 6) chk("cont_rd1", 32'(p1_rdata), 32'h55AB);
    end

    // Lock: locked read then unlocked write on p0 keeps p1 out until p0's 2nd ack
    do_reset();
    p1_wr = 1'b0; p1_be = 2'b11; p1_addr = 11'h020; p1_req = 1'b1;
    p0_wr = 1'b0; p0_lock = 1'b1; p0_be = 2'b11; p0_addr = 11'h010; p0_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("lock_ack0", 32'(p0_ack), 32'((k == 3) || (k == 7)));
      chk("lock_ack1", 32'(p1_ack), 32'(k == 10));
      if (k == 3) begin
        p0_wr = 1'b1; p0_lock = 1'b0; p0_addr = 11'h040; p0_wdata = 16'hC0DE;
      end
      if (k == 7) p0_req = 1'b0;
      if (k == 10) p1_req = 1'b0;
    end
    chk("lock_mem", 32'(mem[11'h040]), 32'hC0DE);

    // Reset during ACCESS of a write drops wren and address at once
    do_reset();
    p0_wr = 1'b1; p0_lock = 1'b0; p0_be = 2'b11; p0_addr = 11'h050; p0_wdata = 16'hA5A5;
    p0_req = 1'b1;
    tick();
    chk("mid_wren_pre", 32'(ram_wren), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_wren",  32'(ram_wren), 32'd0);
    chk("mid_ack",   32'(p0_ack), 32'd0);
    chk("mid_addr",  32'(ram_address), 32'd0);
    p0_req = 1'b0;
    tick();
    tick();
    chk("mid_ack_hold", 32'(p0_ack), 32'd0);
    reset = 1'b0;
    do_access(1'b0, 1'b0, 1'b0, 2'b11, 11'h010, 16'h0000, lat, rd, wpat);
    chk("mid_re_lat",  32'(lat), 32'd3);
    chk("mid_re_data", 32'(rd), 32'hBEEF);

    // Zero byte enables: completes, no RAM write, rdata untouched
    tick();
    do_access(1'b1, 1'b0, 1'b0, 2'b11, 11'h010, 16'h0000, lat, rd, wpat);
    chk("zb_pre_rd", 32'(rd), 32'hBEEF);
    tick();
    do_access(1'b1, 1'b1, 1'b0, 2'b00, 11'h020, 16'hFFFF, lat, rd, wpat);
    chk("zb_lat",   32'(lat), 32'd3);
    chk("zb_wren",  32'(wpat), 32'd0);
    chk("zb_rdata", 32'(rd), 32'hBEEF);
    tick();
    chk("zb_mem",   32'(mem[11'h020]), 32'h55AB);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
